// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: entry layout and the issue bubble encoding.
package alu_rs_pkg;

    localparam int RS_WIDTH = 31;
    localparam int RS_ROB   = 2;
    localparam int RS_CTRL  = 3;

    typedef struct packed {
        logic                     rdy;
        logic [RS_ROB:0]          tag;
        logic signed [RS_WIDTH:0] val;
    } rs_operand_t;

    typedef struct packed {
        logic            busy;
        rs_operand_t     op1;
        rs_operand_t     op2;
        logic [RS_CTRL:0] ctrl;
        logic [RS_ROB:0]  rob;
    } rs_entry_t;

    localparam logic [RS_CTRL:0] INFO_BUBBLE = '1;

    // Distance from the ROB head; wraps naturally at the tag width.
    function automatic logic [RS_ROB:0] rs_age(input logic [RS_ROB:0] rob,
                                               input logic [RS_ROB:0] head);
        return rob - head;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB, commit and issue signals of the ALU reservation station.
interface alu_issue_queue_if
    import alu_rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = RS_WIDTH,
    parameter int ROB     = RS_ROB,
    parameter int C_WIDTH = RS_CTRL
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    dispatchValid;
    logic                    ready1;
    logic                    ready2;
    logic signed [WIDTH:0]   value1;
    logic signed [WIDTH:0]   value2;
    logic [ROB:0]            rob1;
    logic [ROB:0]            rob2;
    logic [ROB:0]            robInstr;
    logic [C_WIDTH:0]        ALUControl;
    logic                    cdbValid;
    logic [ROB:0]            cdbRob;
    logic signed [WIDTH:0]   cdbValue;
    logic [ROB:0]            robHead;
    logic                    clear;
    logic                    validCommit;
    logic                    execute;
    logic                    full;
    logic [CNT_W-1:0]        freeCount;
    logic                    issueValid;
    logic signed [WIDTH:0]   src1;
    logic signed [WIDTH:0]   src2;
    logic [C_WIDTH:0]        instrInfo;
    logic [ROB:0]            instrRob;

    modport slave (
        input  dispatchValid, ready1, ready2, value1, value2, rob1, rob2, robInstr,
               ALUControl, cdbValid, cdbRob, cdbValue, robHead, clear, validCommit, execute,
        output full, freeCount, issueValid, src1, src2, instrInfo, instrRob
    );

    modport master (
        output dispatchValid, ready1, ready2, value1, value2, rob1, rob2, robInstr,
               ALUControl, cdbValid, cdbRob, cdbValue, robHead, clear, validCommit, execute,
        input  full, freeCount, issueValid, src1, src2, instrInfo, instrRob
    );

endinterface

// File: rtl/alu_rs_entry.sv
// One reservation-station slot: operand storage, CDB wakeup with dispatch bypass, issue request.
module alu_rs_entry
    import alu_rs_pkg::*;
#(
    parameter int WIDTH   = RS_WIDTH,
    parameter int ROB     = RS_ROB,
    parameter int C_WIDTH = RS_CTRL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  alloc_i,
    input  logic                  issue_i,
    input  logic                  ready1_i,
    input  logic                  ready2_i,
    input  logic signed [WIDTH:0] value1_i,
    input  logic signed [WIDTH:0] value2_i,
    input  logic [ROB:0]          rob1_i,
    input  logic [ROB:0]          rob2_i,
    input  logic [ROB:0]          rob_instr_i,
    input  logic [C_WIDTH:0]      ctrl_i,
    input  logic                  cdb_valid_i,
    input  logic [ROB:0]          cdb_rob_i,
    input  logic signed [WIDTH:0] cdb_value_i,
    output rs_entry_t             entry_o,
    output logic                  req_o
);

    logic                  busy_q, busy_d;
    logic                  rdy1_q, rdy1_d;
    logic                  rdy2_q, rdy2_d;
    logic [ROB:0]          tag1_q, tag1_d;
    logic [ROB:0]          tag2_q, tag2_d;
    logic signed [WIDTH:0] val1_q, val1_d;
    logic signed [WIDTH:0] val2_q, val2_d;
    logic [C_WIDTH:0]      ctrl_q, ctrl_d;
    logic [ROB:0]          rob_q, rob_d;

    logic hit1, hit2, byp1, byp2;

    assign hit1 = cdb_valid_i && (cdb_rob_i == tag1_q);
    assign hit2 = cdb_valid_i && (cdb_rob_i == tag2_q);
    assign byp1 = cdb_valid_i && !ready1_i && (cdb_rob_i == rob1_i);
    assign byp2 = cdb_valid_i && !ready2_i && (cdb_rob_i == rob2_i);

    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        val1_d = val1_q;
        val2_d = val2_q;
        ctrl_d = ctrl_q;
        rob_d  = rob_q;
        if (busy_q && !rdy1_q && hit1) begin
            rdy1_d = 1'b1;
            val1_d = cdb_value_i;
        end
        if (busy_q && !rdy2_q && hit2) begin
            rdy2_d = 1'b1;
            val2_d = cdb_value_i;
        end
        // An operand whose producer broadcasts in the dispatch cycle is captured ready.
        if (alloc_i) begin
            busy_d = 1'b1;
            rdy1_d = ready1_i | byp1;
            rdy2_d = ready2_i | byp2;
            tag1_d = rob1_i;
            tag2_d = rob2_i;
            val1_d = byp1 ? cdb_value_i : value1_i;
            val2_d = byp2 ? cdb_value_i : value2_i;
            ctrl_d = ctrl_i;
            rob_d  = rob_instr_i;
        end
        if (issue_i || flush_i) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            rdy1_q <= 1'b0;
            rdy2_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
        end
    end

    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
        ctrl_q <= ctrl_d;
        rob_q  <= rob_d;
    end

    assign req_o = busy_q & rdy1_q & rdy2_q;

    always_comb begin
        entry_o.busy     = busy_q;
        entry_o.op1.rdy  = rdy1_q;
        entry_o.op1.tag  = tag1_q;
        entry_o.op1.val  = val1_q;
        entry_o.op2.rdy  = rdy2_q;
        entry_o.op2.tag  = tag2_q;
        entry_o.op2.val  = val2_q;
        entry_o.ctrl     = ctrl_q;
        entry_o.rob      = rob_q;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered ALU reservation station with self-managed free slots and a registered issue stage.
// Build option ALU_RS_AGE_SELECT_EN: oldest-first select by ROB age; undefined gives lowest-index select.
module alu_issue_queue
    import alu_rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = RS_WIDTH,
    parameter int ROB     = RS_ROB,
    parameter int C_WIDTH = RS_CTRL
) (
    input  logic              clk,
    input  logic              globalReset,
    alu_issue_queue_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   req;
    logic [DEPTH-1:0]   busy;
    logic [DEPTH-1:0]   alloc_vec;
    logic [DEPTH-1:0]   issue_vec;
    logic [CNT_W-1:0]   free_cnt;
    logic               full;
    logic               flush;
    logic               alloc_found;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    rs_entry_t          sel_entry;
    logic               do_issue;

    logic                  issue_valid_q, issue_valid_d;
    logic signed [WIDTH:0] src1_q, src1_d;
    logic signed [WIDTH:0] src2_q, src2_d;
    logic [C_WIDTH:0]      info_q, info_d;
    logic [ROB:0]          irob_q, irob_d;

    assign flush = bus.clear & bus.validCommit;
    assign full  = &busy;

    // Lowest free slot; full is taken from the current state so a slot freed this cycle is not reused.
    always_comb begin
        free_cnt    = '0;
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!alloc_found && bus.dispatchValid && !flush) begin
                    alloc_vec[i] = 1'b1;
                    alloc_found  = 1'b1;
                end
            end
        end
    end

`ifdef ALU_RS_AGE_SELECT_EN
    logic [ROB:0] best_age;

    // Strict compare keeps the lower index on equal age.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!sel_found || (rs_age(entries[i].rob, bus.robHead) < best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = rs_age(entries[i].rob, bus.robHead);
            end
        end
    end
`else
    logic unused_head;
    assign unused_head = ^bus.robHead;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign do_issue  = bus.execute & sel_found & ~flush;
    assign sel_entry = entries[sel_idx];

    always_comb begin
        issue_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_vec[i] = do_issue && (sel_idx == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        alu_rs_entry #(
            .WIDTH   (WIDTH),
            .ROB     (ROB),
            .C_WIDTH (C_WIDTH)
        ) u_entry (
            .clk         (clk),
            .rst         (globalReset),
            .flush_i     (flush),
            .alloc_i     (alloc_vec[g]),
            .issue_i     (issue_vec[g]),
            .ready1_i    (bus.ready1),
            .ready2_i    (bus.ready2),
            .value1_i    (bus.value1),
            .value2_i    (bus.value2),
            .rob1_i      (bus.rob1),
            .rob2_i      (bus.rob2),
            .rob_instr_i (bus.robInstr),
            .ctrl_i      (bus.ALUControl),
            .cdb_valid_i (bus.cdbValid),
            .cdb_rob_i   (bus.cdbRob),
            .cdb_value_i (bus.cdbValue),
            .entry_o     (entries[g]),
            .req_o       (req[g])
        );
        assign busy[g] = entries[g].busy;
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        info_d        = info_q;
        irob_d        = irob_q;
        if (flush || (bus.execute && !sel_found)) begin
            issue_valid_d = 1'b0;
            src1_d        = '0;
            src2_d        = '0;
            info_d        = INFO_BUBBLE;
            irob_d        = '0;
        end else if (do_issue) begin
            issue_valid_d = 1'b1;
            src1_d        = sel_entry.op1.val;
            src2_d        = sel_entry.op2.val;
            info_d        = sel_entry.ctrl;
            irob_d        = sel_entry.rob;
        end
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            issue_valid_q <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            info_q        <= INFO_BUBBLE;
            irob_q        <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            info_q        <= info_d;
            irob_q        <= irob_d;
        end
    end

    assign bus.full       = full;
    assign bus.freeCount  = free_cnt;
    assign bus.issueValid = issue_valid_q;
    assign bus.src1       = src1_q;
    assign bus.src2       = src2_q;
    assign bus.instrInfo  = info_q;
    assign bus.instrRob   = irob_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus a randomized run against a behavioural model.
module tb_alu_issue_queue;
    import alu_rs_pkg::*;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 31;
    localparam int ROB     = 2;
    localparam int C_WIDTH = 3;
    localparam int NTAGS   = 1 << (ROB + 1);

    logic clk = 1'b0;
    logic globalReset;
    int   errors = 0;
    int   checks = 0;

    alu_issue_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ROB(ROB), .C_WIDTH(C_WIDTH)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ROB(ROB), .C_WIDTH(C_WIDTH)) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic                  m_busy [DEPTH];
    logic                  m_r1   [DEPTH];
    logic                  m_r2   [DEPTH];
    logic [ROB:0]          m_t1   [DEPTH];
    logic [ROB:0]          m_t2   [DEPTH];
    logic signed [WIDTH:0] m_v1   [DEPTH];
    logic signed [WIDTH:0] m_v2   [DEPTH];
    logic [C_WIDTH:0]      m_ctrl [DEPTH];
    logic [ROB:0]          m_rob  [DEPTH];
    logic                  e_iv;
    logic signed [WIDTH:0] e_s1, e_s2;
    logic [C_WIDTH:0]      e_info;
    logic [ROB:0]          e_rob;
    int                    e_free;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic exe);
        bus.dispatchValid = 1'b0;
        bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        bus.value1 = '0;   bus.value2 = '0;
        bus.rob1 = '0;     bus.rob2 = '0;
        bus.robInstr = '0; bus.ALUControl = '0;
        bus.cdbValid = 1'b0; bus.cdbRob = '0; bus.cdbValue = '0;
        bus.clear = 1'b0;  bus.validCommit = 1'b0;
        bus.execute = exe;
    endtask

    task automatic disp(input logic [3:0] ctrl, input logic r1, input logic signed [31:0] v1,
                        input logic [2:0] t1, input logic r2, input logic signed [31:0] v2,
                        input logic [2:0] t2, input logic [2:0] rob);
        bus.dispatchValid = 1'b1;
        bus.ALUControl = ctrl;
        bus.ready1 = r1; bus.value1 = v1; bus.rob1 = t1;
        bus.ready2 = r2; bus.value2 = v2; bus.rob2 = t2;
        bus.robInstr = rob;
    endtask

    task automatic test_reset();
        idle(1'b0);
        bus.robHead = '0;
        globalReset = 1'b1;
        #12;
        checks++; if (bus.issueValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.issueValid); end
        checks++; if (bus.src1 !== 32'sd0 || bus.src2 !== 32'sd0) begin errors++; $display("FAIL reset_src: got %0d/%0d want 0/0", bus.src1, bus.src2); end
        checks++; if (bus.instrInfo !== 4'hF) begin errors++; $display("FAIL reset_info: got %h want f", bus.instrInfo); end
        checks++; if (bus.instrRob !== 3'd0) begin errors++; $display("FAIL reset_rob: got %0d want 0", bus.instrRob); end
        checks++; if (bus.full !== 1'b0 || bus.freeCount !== 4'(DEPTH)) begin errors++; $display("FAIL reset_free: got full=%0b cnt=%0d want 0/%0d", bus.full, bus.freeCount, DEPTH); end
        @(posedge clk); #1;
        globalReset = 1'b0;
        step();
        // Asynchronous reset in the middle of activity
        disp(4'h2, 1'b1, 32'sd1, 3'd0, 1'b1, 32'sd2, 3'd0, 3'd1);
        step();
        disp(4'h3, 1'b1, 32'sd3, 3'd0, 1'b1, 32'sd4, 3'd0, 3'd2);
        bus.execute = 1'b1;
        step();
        idle(1'b0);
        checks++; if (bus.issueValid !== 1'b1 || bus.instrRob !== 3'd1 || bus.freeCount !== 4'(DEPTH-1)) begin errors++; $display("FAIL midreset_pre: got v=%0b rob=%0d cnt=%0d want 1/1/%0d", bus.issueValid, bus.instrRob, bus.freeCount, DEPTH-1); end
        #2 globalReset = 1'b1;
        #1;
        checks++; if (bus.issueValid !== 1'b0 || bus.instrInfo !== 4'hF || bus.freeCount !== 4'(DEPTH)) begin errors++; $display("FAIL midreset: got v=%0b info=%h cnt=%0d want 0/f/%0d", bus.issueValid, bus.instrInfo, bus.freeCount, DEPTH); end
        globalReset = 1'b0;
        step();
    endtask

    task automatic test_basic_issue();
        disp(4'h0, 1'b1, 32'sd5, 3'd0, 1'b1, 32'sd7, 3'd0, 3'd3);
        bus.execute = 1'b1;
        step();
        idle(1'b1);
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.src1 !== 32'sd5 || bus.src2 !== 32'sd7) begin errors++; $display("FAIL basic_issue: got v=%0b src=%0d/%0d want 1/5/7", bus.issueValid, bus.src1, bus.src2); end
        checks++; if (bus.instrRob !== 3'd3 || bus.instrInfo !== 4'h0) begin errors++; $display("FAIL basic_tag: got rob=%0d info=%h want 3/0", bus.instrRob, bus.instrInfo); end
        step();
        checks++; if (bus.issueValid !== 1'b0 || bus.instrInfo !== 4'hF || bus.src1 !== 32'sd0 || bus.instrRob !== 3'd0) begin errors++; $display("FAIL basic_bubble: got v=%0b info=%h src1=%0d rob=%0d want 0/f/0/0", bus.issueValid, bus.instrInfo, bus.src1, bus.instrRob); end
        checks++; if (bus.freeCount !== 4'(DEPTH)) begin errors++; $display("FAIL basic_free: got %0d want %0d", bus.freeCount, DEPTH); end
    endtask

    task automatic test_cdb_wakeup();
        disp(4'h1, 1'b0, 32'sd0, 3'd2, 1'b1, 32'sd1, 3'd0, 3'd4);
        bus.execute = 1'b1;
        step();
        idle(1'b1);
        step();
        bus.cdbValid = 1'b1; bus.cdbRob = 3'd2; bus.cdbValue = -32'sd9;
        step();
        bus.cdbValid = 1'b0;
        checks++; if (bus.issueValid !== 1'b0) begin errors++; $display("FAIL wake_early: got v=%0b want 0", bus.issueValid); end
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.src1 !== -32'sd9 || bus.instrRob !== 3'd4) begin errors++; $display("FAIL wake_issue: got v=%0b src1=%0d rob=%0d want 1/-9/4", bus.issueValid, bus.src1, bus.instrRob); end
        step();
    endtask

    task automatic test_dispatch_bypass();
        disp(4'h5, 1'b0, 32'sd0, 3'd4, 1'b1, 32'sd2, 3'd0, 3'd5);
        bus.cdbValid = 1'b1; bus.cdbRob = 3'd4; bus.cdbValue = 32'sd11;
        bus.execute = 1'b1;
        step();
        idle(1'b1);
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.src1 !== 32'sd11 || bus.src2 !== 32'sd2 || bus.instrRob !== 3'd5) begin errors++; $display("FAIL bypass: got v=%0b src=%0d/%0d rob=%0d want 1/11/2/5", bus.issueValid, bus.src1, bus.src2, bus.instrRob); end
        step();
    endtask

    task automatic test_select_order();
        logic [2:0] first_rob, second_rob;
`ifdef ALU_RS_AGE_SELECT_EN
        first_rob = 3'd7; second_rob = 3'd1;
`else
        first_rob = 3'd1; second_rob = 3'd7;
`endif
        bus.robHead = 3'd6;
        idle(1'b0);
        disp(4'h6, 1'b1, 32'sd100, 3'd0, 1'b1, 32'sd101, 3'd0, 3'd1);
        step();
        disp(4'h7, 1'b1, 32'sd200, 3'd0, 1'b1, 32'sd201, 3'd0, 3'd7);
        step();
        idle(1'b1);
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.instrRob !== first_rob) begin errors++; $display("FAIL select_first: got v=%0b rob=%0d want 1/%0d", bus.issueValid, bus.instrRob, first_rob); end
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.instrRob !== second_rob) begin errors++; $display("FAIL select_second: got v=%0b rob=%0d want 1/%0d", bus.issueValid, bus.instrRob, second_rob); end
        step();
        bus.robHead = 3'd0;
    endtask

    task automatic test_full_flush();
        bus.execute = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'h8, 1'b0, 32'sd0, 3'd0, 1'b1, 32'(i), 3'd0, 3'(i));
            step();
        end
        idle(1'b1);
        checks++; if (bus.full !== 1'b1 || bus.freeCount !== 4'd0) begin errors++; $display("FAIL full: got full=%0b cnt=%0d want 1/0", bus.full, bus.freeCount); end
        disp(4'h9, 1'b1, 32'sd1, 3'd0, 1'b1, 32'sd1, 3'd0, 3'd7);
        step();
        idle(1'b1);
        checks++; if (bus.freeCount !== 4'd0 || bus.issueValid !== 1'b0) begin errors++; $display("FAIL full_ignore: got cnt=%0d v=%0b want 0/0", bus.freeCount, bus.issueValid); end
        bus.cdbValid = 1'b1; bus.cdbRob = 3'd0; bus.cdbValue = 32'sd3;
        step();
        idle(1'b1);
        bus.clear = 1'b1; bus.validCommit = 1'b1;
        step();
        idle(1'b1);
        checks++; if (bus.issueValid !== 1'b0 || bus.instrInfo !== 4'hF || bus.freeCount !== 4'(DEPTH) || bus.full !== 1'b0) begin errors++; $display("FAIL flush: got v=%0b info=%h cnt=%0d full=%0b want 0/f/%0d/0", bus.issueValid, bus.instrInfo, bus.freeCount, bus.full, DEPTH); end
        step();
        checks++; if (bus.issueValid !== 1'b0) begin errors++; $display("FAIL flush_after: got v=%0b want 0", bus.issueValid); end
    endtask

    task automatic test_execute_hold();
        disp(4'hA, 1'b1, 32'sd21, 3'd0, 1'b1, 32'sd22, 3'd0, 3'd2);
        bus.execute = 1'b1;
        step();
        idle(1'b1);
        step();
        disp(4'hB, 1'b1, 32'sd31, 3'd0, 1'b1, 32'sd32, 3'd0, 3'd5);
        bus.execute = 1'b0;
        step();
        idle(1'b0);
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.instrRob !== 3'd2 || bus.src1 !== 32'sd21 || bus.instrInfo !== 4'hA) begin errors++; $display("FAIL hold_out: got v=%0b rob=%0d src1=%0d info=%h want 1/2/21/a", bus.issueValid, bus.instrRob, bus.src1, bus.instrInfo); end
        checks++; if (bus.freeCount !== 4'(DEPTH-1)) begin errors++; $display("FAIL hold_busy: got %0d want %0d", bus.freeCount, DEPTH-1); end
        bus.execute = 1'b1;
        step();
        checks++; if (bus.issueValid !== 1'b1 || bus.instrRob !== 3'd5 || bus.src1 !== 32'sd31 || bus.src2 !== 32'sd32) begin errors++; $display("FAIL hold_release: got v=%0b rob=%0d src=%0d/%0d want 1/5/31/32", bus.issueValid, bus.instrRob, bus.src1, bus.src2); end
        step();
        checks++; if (bus.freeCount !== 4'(DEPTH)) begin errors++; $display("FAIL hold_free: got %0d want %0d", bus.freeCount, DEPTH); end
    endtask

    // Applies one cycle of the station's rules to the model using the inputs currently driven.
    task automatic model_cycle();
        int nfree, slot, sel, best, key;
        if (bus.clear && bus.validCommit) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            e_iv = 1'b0; e_s1 = '0; e_s2 = '0; e_info = 4'hF; e_rob = '0;
        end else begin
            nfree = 0; slot = -1; sel = -1; best = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!m_busy[i]) begin
                    nfree++;
                    if (slot < 0) slot = i;
                end else if (m_r1[i] && m_r2[i]) begin
`ifdef ALU_RS_AGE_SELECT_EN
                    key = (int'(m_rob[i]) - int'(bus.robHead) + NTAGS) % NTAGS;
`else
                    key = i;
`endif
                    if (sel < 0 || key < best) begin sel = i; best = key; end
                end
            end
            if (bus.execute) begin
                if (sel >= 0) begin
                    e_iv = 1'b1; e_s1 = m_v1[sel]; e_s2 = m_v2[sel]; e_info = m_ctrl[sel]; e_rob = m_rob[sel];
                    m_busy[sel] = 1'b0;
                end else begin
                    e_iv = 1'b0; e_s1 = '0; e_s2 = '0; e_info = 4'hF; e_rob = '0;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && bus.cdbValid) begin
                    if (!m_r1[i] && m_t1[i] == bus.cdbRob) begin m_r1[i] = 1'b1; m_v1[i] = bus.cdbValue; end
                    if (!m_r2[i] && m_t2[i] == bus.cdbRob) begin m_r2[i] = 1'b1; m_v2[i] = bus.cdbValue; end
                end
            end
            if (bus.dispatchValid && nfree > 0) begin
                m_busy[slot] = 1'b1;
                m_t1[slot] = bus.rob1; m_t2[slot] = bus.rob2;
                m_ctrl[slot] = bus.ALUControl; m_rob[slot] = bus.robInstr;
                m_r1[slot] = bus.ready1 || (bus.cdbValid && bus.cdbRob == bus.rob1);
                m_r2[slot] = bus.ready2 || (bus.cdbValid && bus.cdbRob == bus.rob2);
                m_v1[slot] = (!bus.ready1 && bus.cdbValid && bus.cdbRob == bus.rob1) ? bus.cdbValue : bus.value1;
                m_v2[slot] = (!bus.ready2 && bus.cdbValid && bus.cdbRob == bus.rob2) ? bus.cdbValue : bus.value2;
            end
        end
        e_free = 0;
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) e_free++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle(1'b0);
            if (c == 0) begin
                bus.clear = 1'b1; bus.validCommit = 1'b1; bus.execute = 1'b1;
            end else begin
                bus.dispatchValid = ($urandom_range(0, 99) < 60);
                bus.ready1 = $urandom_range(0, 1); bus.ready2 = $urandom_range(0, 1);
                bus.value1 = $signed($urandom); bus.value2 = $signed($urandom);
                bus.rob1 = 3'($urandom_range(0, 7)); bus.rob2 = 3'($urandom_range(0, 7));
                bus.robInstr = 3'($urandom_range(0, 7));
                bus.ALUControl = 4'($urandom_range(0, 15));
                bus.cdbValid = ($urandom_range(0, 99) < 40);
                bus.cdbRob = 3'($urandom_range(0, 7));
                bus.cdbValue = $signed($urandom);
                bus.robHead = 3'($urandom_range(0, 7));
                bus.execute = ($urandom_range(0, 99) < 75);
                bus.clear = ($urandom_range(0, 99) < 6);
                bus.validCommit = $urandom_range(0, 1);
            end
            model_cycle();
            step();
            checks++; if (bus.issueValid !== e_iv) begin errors++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, bus.issueValid, e_iv); end
            checks++; if (bus.src1 !== e_s1 || bus.src2 !== e_s2) begin errors++; $display("FAIL rnd_src c=%0d: got %0d/%0d want %0d/%0d", c, bus.src1, bus.src2, e_s1, e_s2); end
            checks++; if (bus.instrInfo !== e_info || bus.instrRob !== e_rob) begin errors++; $display("FAIL rnd_tag c=%0d: got info=%h rob=%0d want %h/%0d", c, bus.instrInfo, bus.instrRob, e_info, e_rob); end
            checks++; if (bus.freeCount !== 4'(e_free) || bus.full !== (e_free == 0)) begin errors++; $display("FAIL rnd_free c=%0d: got cnt=%0d full=%0b want %0d", c, bus.freeCount, bus.full, e_free); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_dispatch_bypass();
        test_select_order();
        test_full_flush();
        test_execute_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Parametrised, age-ordered ALU reservation station that replaces the fixed four-entry ALU station. It accepts one renamed ALU instruction per cycle from dispatch, captures operands from the common data bus, and issues the oldest ready instruction to the ALU through a registered output stage. It allocates its own free slots, so the dispatch stage only watches `full`. It also provides an explicit issue-valid qualifier.

## Interface
Parameters:
- `DEPTH`, 8: number of entries, at least 2.
- `WIDTH`, 31: MSB index of the operand data.
- `ROB`, 2: MSB index of the ROB tag.
- `C_WIDTH`, 3: MSB index of the ALU control field.

Ports:
- `clk`  in  1  sole clock. Rising edge.
- `globalReset`  in  1  asynchronous, active-high reset.
- `dispatchValid`  in  1  dispatch is writing an instruction this cycle.
- `ready1`, `ready2`  in  1  the matching operand value is already valid.
- `value1`, `value2`  in  WIDTH+1 (signed)  operand values.
- `rob1`, `rob2`  in  ROB+1  producer tags, used when the matching ready bit is low.
- `robInstr`  in  ROB+1  destination ROB tag of the instruction.
- `ALUControl`  in  C_WIDTH+1  ALU operation code.
- `cdbValid`  in  1  CDB broadcast is valid.
- `cdbRob`  in  ROB+1  tag of the broadcast.
- `cdbValue`  in  WIDTH+1 (signed)  value of the broadcast.
- `robHead`  in  ROB+1  oldest in-flight ROB tag.
- `clear`, `validCommit`  in  1  flush occurs when both are high.
- `execute`  in  1  the ALU can accept an instruction this cycle.
- `full`  out  1  no free entry.
- `freeCount`  out  $clog2(DEPTH+1)  number of free entries.
- `issueValid`  out  1  the registered output holds a real instruction.
- `src1`, `src2`  out  WIDTH+1 (signed)  issued operands.
- `instrInfo`  out  C_WIDTH+1  issued control field. All ones when `issueValid` is low.
- `instrRob`  out  ROB+1  ROB tag of the issued instruction.

## Operation
- Each entry holds:
  - `busy`
  - two `{rdy, tag, val}` operand records
  - `ctrl`
  - `rob`
- Allocation:
  - When `dispatchValid` is high and `full` is low, the instruction is written into the lowest-index free entry.
  - When `full` is high, dispatch is ignored. `full` is evaluated on the current state, so a slot being freed in the same cycle cannot be used.
- Wakeup:
  - An operand captures the value when `cdbValid` is high, the operand is not ready, and `cdbRob` equals its tag. Its `rdy` bit is then set.
  - Dispatch bypass: if the CDB tag matches the operand arriving through dispatch in the same cycle, the entry is written with `rdy=1` and `cdbValue`.
- Request: an entry requests issue when `busy` is high and both operand `rdy` bits are high.
- Select:
  - Among requesting entries, pick the smallest age, where age = (rob − robHead) mod 2^(ROB+1).
  - If two requesters have equal age, the lower index wins.
- Issue, only when `execute` is high and a request exists:
  - The selected entry's fields are registered to the outputs.
  - `issueValid` is set to 1.
  - The selected entry's `busy` is cleared.
- When `execute` is high and no request exists, the outputs take the bubble value: `issueValid=0`, `src1=src2=0`, `instrInfo='1`, `instrRob=0`.
- When `execute` is low, the outputs hold their value and no entry is freed.
- Flush (`clear & validCommit`):
  - All entries become free.
  - The outputs take the bubble value.
  - Flush wins over dispatch, wakeup and issue in the same cycle.

## Timing
- Reset values:
  - All entries are free.
  - `full=0`.
  - `freeCount=DEPTH`.
  - The outputs hold the bubble value.
- An instruction dispatched ready in cycle t is written at the edge ending cycle t. It can request in cycle t+1, and its outputs are visible in cycle t+2.
- A CDB wakeup in cycle t allows the instruction to request in cycle t+1. There is no same-cycle wakeup-to-select path.
- `full` and `freeCount` are combinational from the entry state. They reflect dispatch and issue one cycle later.
- Dispatch and issue can happen in the same cycle, into different entries.
- Reset can be asserted mid-operation: the state is cleared asynchronously, with no partial issue.

## Configuration
- `ALU_RS_AGE_SELECT_EN` defined: age-ordered select as described above.
- `ALU_RS_AGE_SELECT_EN` undefined:
  - Select is fixed priority, lowest index first.
  - `robHead` is unused.
  - Everything else is identical.

## Structure
- Package `alu_rs_pkg` contains:
  - the `rs_operand_t` and `rs_entry_t` packed typedefs
  - the bubble constant for `instrInfo`
- Sub-module `alu_rs_entry` contains one entry's storage, its wakeup comparators and its request generation. It is instantiated DEPTH times with a generate loop.
- Free-slot and age selection, along with the output register, stay in the top module.

## Test plan
1. Reset, then dispatch `ALUControl=4'b0000`, `value1=5`, `value2=7`, both ready, `robInstr=3`, with `execute=1` → in cycle t+2: `issueValid=1`, `src1=5`, `src2=7`, `instrRob=3`. In cycle t+3 the outputs are the bubble value and `freeCount=DEPTH`.
2. Dispatch with `ready1=0`, `rob1=2`. Broadcast `cdbRob=2`, `cdbValue=-9` two cycles later → the instruction issues with `src1=-9` exactly two cycles after the broadcast.
3. Dispatch with `rob1=4`, with `cdbRob=4` and `cdbValue=11` in the same cycle → issued with `src1=11`, with no further broadcast needed.
4. `robHead=6`. Make entries with rob 1 and rob 7 ready together → rob 7 issues first, then rob 1. With the macro undefined, the lower index issues first.
5. Fill all DEPTH entries with unready instructions → `full=1`, and a further dispatch is ignored (`freeCount` stays 0). Then flush → `freeCount=DEPTH` and `issueValid=0` on the next cycle.
6. Hold `execute=0` while a ready entry is waiting → the outputs are held and the entry stays busy. Raise `execute` → the entry issues on the next edge.
